// File: rtl/mm_wb_stage.sv
// MEM/WB pipeline stage: registered payload with valid/ready handshake, optional
// 2-entry skid buffer, flush, write-back data select and a saturating bubble counter.
module mm_wb_stage #(
    parameter int              XLEN    = 32,
    parameter int              OP_W    = 6,
    parameter int              RD_W    = 5,
    parameter logic [OP_W-1:0] LOAD_OP = 6'b100011,
    parameter int              SKID    = 1,
    parameter int              CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             cnt_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_opcode,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_mem,
    input  logic [RD_W-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  out_opcode,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_alu,
    output logic [XLEN-1:0]  out_mem,
    output logic [RD_W-1:0]  out_rd,
    output logic [XLEN-1:0]  out_wb_data,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int PL_W = OP_W + 3 * XLEN + RD_W;

    logic [PL_W-1:0]  in_pl_s;
    logic [PL_W-1:0]  main_r;
    logic [PL_W-1:0]  main_d_s;
    logic [PL_W-1:0]  skid_r;
    logic [PL_W-1:0]  skid_d_s;
    logic             main_valid_r;
    logic             main_valid_d_s;
    logic             skid_valid_r;
    logic             skid_valid_d_s;
    logic             ready_s;
    logic             accept_s;
    logic [CNT_W-1:0] bubble_cnt_r;

    assign in_pl_s  = {in_opcode, in_pc, in_alu, in_mem, in_rd};
    assign accept_s = in_valid && ready_s;

    // In skid mode readiness depends only on stored state, breaking the out_ready path.
    always_comb begin
        ready_s = 1'b0;
        if (SKID != 0) begin
            ready_s = !skid_valid_r;
        end else begin
            ready_s = !main_valid_r || out_ready;
        end
    end

    // Next-state selection for main and skid registers; flush wins over everything.
    always_comb begin
        main_d_s       = main_r;
        main_valid_d_s = main_valid_r;
        skid_d_s       = skid_r;
        skid_valid_d_s = skid_valid_r;
        if (flush) begin
            main_valid_d_s = 1'b0;
            skid_valid_d_s = 1'b0;
        end else if (SKID != 0) begin
            if (!main_valid_r || out_ready) begin
                if (skid_valid_r) begin
                    main_d_s       = skid_r;
                    main_valid_d_s = 1'b1;
                    if (accept_s) begin
                        skid_d_s       = in_pl_s;
                        skid_valid_d_s = 1'b1;
                    end else begin
                        skid_valid_d_s = 1'b0;
                    end
                end else if (accept_s) begin
                    main_d_s       = in_pl_s;
                    main_valid_d_s = 1'b1;
                end else begin
                    main_valid_d_s = 1'b0;
                end
            end else if (accept_s) begin
                skid_d_s       = in_pl_s;
                skid_valid_d_s = 1'b1;
            end else begin
                skid_valid_d_s = skid_valid_r;
            end
        end else begin
            skid_valid_d_s = 1'b0;
            if (accept_s) begin
                main_d_s       = in_pl_s;
                main_valid_d_s = 1'b1;
            end else if (out_ready) begin
                main_valid_d_s = 1'b0;
            end else begin
                main_valid_d_s = main_valid_r;
            end
        end
    end

    // Storage registers for both entries and their valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r       <= {PL_W{1'b0}};
            skid_r       <= {PL_W{1'b0}};
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            main_r       <= main_d_s;
            skid_r       <= skid_d_s;
            main_valid_r <= main_valid_d_s;
            skid_valid_r <= skid_valid_d_s;
        end
    end

    // Saturating count of cycles where no entry is presented downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (!main_valid_r && (bubble_cnt_r != {CNT_W{1'b1}})) begin
            bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign in_ready   = ready_s;
    assign out_valid  = main_valid_r;
    assign bubble_cnt = bubble_cnt_r;
    assign {out_opcode, out_pc, out_alu, out_mem, out_rd} = main_r;

    // Loads write back memory data, everything else the ALU result.
    always_comb begin
        out_wb_data = {XLEN{1'b0}};
        if (out_opcode == LOAD_OP) begin
            out_wb_data = out_mem;
        end else begin
            out_wb_data = out_alu;
        end
    end

endmodule

// File: tb/tb_mm_wb_stage.sv
// Directed bench for mm_wb_stage: skid, non-skid and 4-bit-counter instances.
module tb_mm_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  opcode;
    logic [31:0] pc, alu, mem;
    logic [4:0]  rd;
    logic        iv0, or0, fl0, clr0;
    logic        iv1, or1, fl1, clr1;
    logic        clr2;

    logic        ir0, ov0, ir1, ov1, ir2, ov2;
    logic [5:0]  op0, op1, op2;
    logic [31:0] pc0, alu0, mem0, wb0, pc1, alu1, mem1, wb1, pc2, alu2, mem2, wb2;
    logic [4:0]  rd0, rd1, rd2;
    logic [15:0] bc0, bc1;
    logic [3:0]  bc2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mm_wb_stage #(.SKID(1)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(fl0), .cnt_clr(clr0),
        .in_valid(iv0), .in_ready(ir0), .in_opcode(opcode), .in_pc(pc),
        .in_alu(alu), .in_mem(mem), .in_rd(rd),
        .out_valid(ov0), .out_ready(or0), .out_opcode(op0), .out_pc(pc0),
        .out_alu(alu0), .out_mem(mem0), .out_rd(rd0), .out_wb_data(wb0),
        .bubble_cnt(bc0)
    );

    mm_wb_stage #(.SKID(0)) u_noskid (
        .clk(clk), .rst_n(rst_n), .flush(fl1), .cnt_clr(clr1),
        .in_valid(iv1), .in_ready(ir1), .in_opcode(opcode), .in_pc(pc),
        .in_alu(alu), .in_mem(mem), .in_rd(rd),
        .out_valid(ov1), .out_ready(or1), .out_opcode(op1), .out_pc(pc1),
        .out_alu(alu1), .out_mem(mem1), .out_rd(rd1), .out_wb_data(wb1),
        .bubble_cnt(bc1)
    );

    mm_wb_stage #(.SKID(1), .CNT_W(4)) u_cnt4 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .cnt_clr(clr2),
        .in_valid(1'b0), .in_ready(ir2), .in_opcode(opcode), .in_pc(pc),
        .in_alu(alu), .in_mem(mem), .in_rd(rd),
        .out_valid(ov2), .out_ready(1'b1), .out_opcode(op2), .out_pc(pc2),
        .out_alu(alu2), .out_mem(mem2), .out_rd(rd2), .out_wb_data(wb2),
        .bubble_cnt(bc2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        opcode = 6'd0; pc = 32'd0; alu = 32'd0; mem = 32'd0; rd = 5'd0;
        iv0 = 1'b1; or0 = 1'b1; fl0 = 1'b0; clr0 = 1'b0;
        iv1 = 1'b1; or1 = 1'b1; fl1 = 1'b0; clr1 = 1'b0;
        clr2 = 1'b0;
        pc = 32'h55; alu = 32'h66; mem = 32'h77; rd = 5'd3; opcode = 6'b100011;
        #2 rst_n = 1'b0;

        // Reset with inputs active
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ov0", ov0, 1'b0);
        check_eq("rst_ir0", ir0, 1'b1);
        check_eq("rst_ir1", ir1, 1'b1);
        check_eq("rst_pc0", pc0, 32'h0);
        check_eq("rst_alu0", alu0, 32'h0);
        check_eq("rst_mem0", mem0, 32'h0);
        check_eq("rst_rd0", rd0, 5'd0);
        check_eq("rst_op0", op0, 6'd0);
        check_eq("rst_wb0", wb0, 32'h0);
        check_eq("rst_bc0", bc0, 16'd0);
        iv0 = 1'b0; iv1 = 1'b0;
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_bc0", bc0, 16'd1);
        check_eq("post_rst_ov0", ov0, 1'b0);

        // Streaming, both modes
        for (int i = 0; i < 8; i++) begin
            pc = 32'(i * 4); alu = 32'(i + 100); mem = 32'h0; rd = 5'(i); opcode = 6'd0;
            iv0 = 1'b1; iv1 = 1'b1;
            @(negedge clk);
            check_eq("str_ir0", ir0, 1'b1);
            check_eq("str_ir1", ir1, 1'b1);
            tick();
            check_eq("str_ov0", ov0, 1'b1);
            check_eq("str_pc0", pc0, 32'(i * 4));
            check_eq("str_ov1", ov1, 1'b1);
            check_eq("str_pc1", pc1, 32'(i * 4));
            check_eq("str_rd0", rd0, 5'(i));
        end
        iv0 = 1'b0; iv1 = 1'b0;
        tick();
        check_eq("str_end_ov0", ov0, 1'b0);
        check_eq("str_end_ov1", ov1, 1'b0);

        // Write-back select
        opcode = 6'b100011; alu = 32'h10; mem = 32'hDEAD; rd = 5'd7; iv0 = 1'b1;
        tick();
        check_eq("wb_load", wb0, 32'hDEAD);
        check_eq("wb_load_op", op0, 6'b100011);
        check_eq("wb_load_alu", alu0, 32'h10);
        opcode = 6'b000000;
        tick();
        check_eq("wb_alu", wb0, 32'h10);
        check_eq("wb_alu_mem", mem0, 32'hDEAD);
        iv0 = 1'b0;
        tick();

        // Back-pressure, skid mode
        or0 = 1'b0; opcode = 6'd0; iv0 = 1'b1; pc = 32'hA0;
        @(negedge clk);
        check_eq("bp_ir_a", ir0, 1'b1);
        tick();
        check_eq("bp_pc_a", pc0, 32'hA0);
        pc = 32'hB0;
        @(negedge clk);
        check_eq("bp_ir_b", ir0, 1'b1);
        tick();
        check_eq("bp_hold_a1", pc0, 32'hA0);
        check_eq("bp_ir_full", ir0, 1'b0);
        pc = 32'hC0;
        tick();
        check_eq("bp_hold_a2", pc0, 32'hA0);
        check_eq("bp_ov_hold", ov0, 1'b1);
        check_eq("bp_ir_full2", ir0, 1'b0);
        or0 = 1'b1;
        tick();
        check_eq("bp_out_b", pc0, 32'hB0);
        check_eq("bp_ir_back", ir0, 1'b1);
        tick();
        iv0 = 1'b0;
        check_eq("bp_out_c", pc0, 32'hC0);
        check_eq("bp_ov_c", ov0, 1'b1);
        tick();
        check_eq("bp_drained", ov0, 1'b0);

        // Back-pressure, single register
        or1 = 1'b0; iv1 = 1'b1; pc = 32'hA0;
        @(negedge clk);
        check_eq("bp1_ir_a", ir1, 1'b1);
        tick();
        check_eq("bp1_pc_a", pc1, 32'hA0);
        check_eq("bp1_ir_held", ir1, 1'b0);
        pc = 32'hB0;
        tick();
        check_eq("bp1_hold_a", pc1, 32'hA0);
        check_eq("bp1_ir_held2", ir1, 1'b0);
        or1 = 1'b1;
        #1;
        check_eq("bp1_ir_comb", ir1, 1'b1);
        tick();
        check_eq("bp1_out_b", pc1, 32'hB0);
        iv1 = 1'b0;
        tick();
        check_eq("bp1_drained", ov1, 1'b0);

        // Flush with main and skid full and input offered
        or0 = 1'b0; iv0 = 1'b1; pc = 32'h100;
        tick();
        pc = 32'h104;
        tick();
        pc = 32'h108; fl0 = 1'b1;
        @(negedge clk);
        check_eq("fl_ir_full", ir0, 1'b0);
        tick();
        fl0 = 1'b0; iv0 = 1'b0;
        check_eq("fl_ov", ov0, 1'b0);
        check_eq("fl_ir", ir0, 1'b1);
        or0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("fl_gone", ov0, 1'b0);
        end

        // Flush discards an entry accepted in the same cycle
        or0 = 1'b0; iv0 = 1'b1; pc = 32'h200;
        tick();
        pc = 32'h204; fl0 = 1'b1;
        @(negedge clk);
        check_eq("fl2_ir", ir0, 1'b1);
        tick();
        fl0 = 1'b0; iv0 = 1'b0;
        check_eq("fl2_ov", ov0, 1'b0);
        tick();
        check_eq("fl2_ov_next", ov0, 1'b0);
        or0 = 1'b1;

        // Bubble counter saturation and clear on a 4-bit counter
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        check_eq("bc_clr0", bc2, 4'd0);
        repeat (20) tick();
        check_eq("bc_sat", bc2, 4'd15);
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        check_eq("bc_clr", bc2, 4'd0);
        tick();
        check_eq("bc_resume1", bc2, 4'd1);
        tick();
        check_eq("bc_resume2", bc2, 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_wb_stage.md
# mm_wb_stage

Parametrised MEM/WB pipeline stage for the pipelined processor, sitting between the memory-access stage and write-back. Carries opcode, PC, ALU result, memory read data and destination register, all registered, with a valid/ready handshake, an optional 2-entry skid buffer, and a squash (flush) input. Also selects the write-back data and counts bubble cycles for performance monitoring.

## Interface
- XLEN, 32, width of PC, ALU result, memory data, write-back data
- OP_W, 6, opcode width
- RD_W, 5, destination register index width
- LOAD_OP, 6'b100011, opcode value whose write-back source is memory data
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register
- CNT_W, 16, bubble counter width

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  squash all held entries
- cnt_clr  in  1  synchronous clear of bubble_cnt
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- in_opcode  in  OP_W
- in_pc  in  XLEN
- in_alu  in  XLEN
- in_mem  in  XLEN  memory read data, sampled like all other payload
- in_rd  in  RD_W
- out_valid  out  1
- out_ready  in  1  write-back accepts
- out_opcode, out_pc, out_alu, out_mem, out_rd  out  widths as inputs, registered payload
- out_wb_data  out  XLEN  out_mem if out_opcode == LOAD_OP, else out_alu (combinational from registered payload)
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid == 0

## Operation
- Storage: main register (drives outputs) plus, when SKID=1, one skid register; each has its own valid bit.
- Accept: in_valid && in_ready. Drain: out_valid && out_ready.
- SKID=0: in_ready = !out_valid || out_ready (combinational). On accept, main loads input.
- SKID=1: in_ready = !skid_valid (registered, no combinational path from out_ready).
  - Main empty or draining: main loads skid if skid_valid, else the input if accepted; skid loads the input if skid was valid and input accepted.
  - Main full and not draining: accepted input goes to skid.
- Ordering strictly FIFO; no entry duplicated or dropped except by flush.
- Payload of main held stable while out_valid && !out_ready.
- flush: at the next edge, all valid bits clear. It has priority over accept and drain; an input accepted in the flush cycle is discarded. Payload registers need not clear.
- bubble_cnt: +1 each edge where out_valid == 0, saturates at 2^CNT_W-1; cnt_clr sets it to 0 (priority over increment).
- Reset (rst_n low, immediate): all valids 0, all payload outputs 0, bubble_cnt 0; in_ready = 1 in both modes.

## Timing
- Latency: an entry accepted at edge N appears at out_valid after edge N (1 cycle) when main is empty.
- Throughput: 1 entry/cycle with out_ready held high, both modes.
- SKID=1: after out_ready falls, absorbs exactly one more entry; in_ready drops the cycle after skid fills and returns the cycle after it empties.
- out_wb_data valid in the same cycle as out_valid; no extra latency.
- Reset asserted mid-stream clears all entries asynchronously; first accept possible at the first edge after rst_n rises.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, all outputs 0, in_ready=1, bubble_cnt=0; release, one cycle later bubble_cnt still counts from 0.
- Streaming: 8 entries pc=0x00..0x1C, out_ready=1 -> each appears exactly 1 cycle after accept, in order, no gaps.
- Write-back select: opcode=6'b100011, alu=0x10, mem=0xDEAD -> out_wb_data=0xDEAD; opcode=6'b000000 same data -> out_wb_data=0x10.
- Back-pressure (SKID=1): out_ready=0 while feeding A,B,C -> A held on outputs, B in skid, in_ready=0, C not accepted; raise out_ready -> A,B,C emerge in order. Repeat SKID=0: in_ready=0 while A is held.
- Flush: with main and skid full and in_valid=1, assert flush one cycle -> next cycle out_valid=0, in_ready=1, none of the three entries ever appear.
- Bubble counter: CNT_W=4, 20 idle cycles -> bubble_cnt=15 (saturated); cnt_clr one cycle -> 0, then resumes counting.
